// File: rtl/cu_seq_pkg.sv
// Shared definitions for the cu_seq control unit: state encodings, opcodes
// and ALU operation codes used by cu_seq_param and its flag register.
package cu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_MOV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_STO  = 4'd9;
    localparam logic [3:0] OP_LDI  = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd11;
    localparam logic [3:0] OP_JE   = 4'd12;
    localparam logic [3:0] OP_JNE  = 4'd13;
    localparam logic [3:0] OP_JC   = 4'd14;
    localparam logic [3:0] OP_JMP  = 4'd15;

    // Execute states share their encoding with the opcode (MSB clear), so
    // DECODE can jump straight to {1'b0, opcode}.
    localparam logic [4:0] ENC_ADD     = {1'b0, OP_ADD};
    localparam logic [4:0] ENC_SUB     = {1'b0, OP_SUB};
    localparam logic [4:0] ENC_CMP     = {1'b0, OP_CMP};
    localparam logic [4:0] ENC_MOV     = {1'b0, OP_MOV};
    localparam logic [4:0] ENC_SHL     = {1'b0, OP_SHL};
    localparam logic [4:0] ENC_SHR     = {1'b0, OP_SHR};
    localparam logic [4:0] ENC_INC     = {1'b0, OP_INC};
    localparam logic [4:0] ENC_DEC     = {1'b0, OP_DEC};
    localparam logic [4:0] ENC_LD      = {1'b0, OP_LD};
    localparam logic [4:0] ENC_STO     = {1'b0, OP_STO};
    localparam logic [4:0] ENC_LDI     = {1'b0, OP_LDI};
    localparam logic [4:0] ENC_HALT    = {1'b0, OP_HALT};
    localparam logic [4:0] ENC_JE      = {1'b0, OP_JE};
    localparam logic [4:0] ENC_JNE     = {1'b0, OP_JNE};
    localparam logic [4:0] ENC_JC      = {1'b0, OP_JC};
    localparam logic [4:0] ENC_JMP     = {1'b0, OP_JMP};
    localparam logic [4:0] ENC_RESET   = 5'd16;
    localparam logic [4:0] ENC_FETCH   = 5'd17;
    localparam logic [4:0] ENC_DECODE  = 5'd18;
    localparam logic [4:0] ENC_ILLEGAL = 5'd19;

    typedef enum logic [4:0] {
        ST_ADD     = ENC_ADD,
        ST_SUB     = ENC_SUB,
        ST_CMP     = ENC_CMP,
        ST_MOV     = ENC_MOV,
        ST_SHL     = ENC_SHL,
        ST_SHR     = ENC_SHR,
        ST_INC     = ENC_INC,
        ST_DEC     = ENC_DEC,
        ST_LD      = ENC_LD,
        ST_STO     = ENC_STO,
        ST_LDI     = ENC_LDI,
        ST_HALT    = ENC_HALT,
        ST_JE      = ENC_JE,
        ST_JNE     = ENC_JNE,
        ST_JC      = ENC_JC,
        ST_JMP     = ENC_JMP,
        ST_RESET   = ENC_RESET,
        ST_FETCH   = ENC_FETCH,
        ST_DECODE  = ENC_DECODE,
        ST_ILLEGAL = ENC_ILLEGAL
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_MEM  = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_INC  = 3'd4;
    localparam logic [2:0] ALU_DEC  = 3'd5;
    localparam logic [2:0] ALU_SHR  = 3'd6;
    localparam logic [2:0] ALU_SHL  = 3'd7;

endpackage

// File: rtl/cu_seq_flags.sv
// Processor status flags (N, Z, C) captured from the ALU when ld_en is high.
module cu_seq_flags (
    input  logic clk,
    input  logic reset,
    input  logic ld_en,
    input  logic n,
    input  logic z,
    input  logic c,
    output logic ps_n,
    output logic ps_z,
    output logic ps_c
);

    // Capture the ALU flags at the end of a flag-setting instruction, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {ps_n, ps_z, ps_c} <= 3'b000;
        end else if (ld_en) begin
            {ps_n, ps_z, ps_c} <= {n, z, c};
        end
    end

endmodule

// File: rtl/cu_seq_param.sv
// Multi-cycle control sequencer: FETCH, DECODE, one execute state per opcode.
// Optional macro CU_SEQ_MEM_WAIT_EN: when defined, FETCH/LD/STO/LDI stall
// until mem_rdy; when undefined, mem_rdy is ignored and memory is always ready.
module cu_seq_param
    import cu_seq_pkg::*;
#(
    parameter int          RA_W         = 3,
    parameter int          ALU_W        = 4,
    parameter logic [15:0] ILLEGAL_MASK = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      ir,
    input  logic             n,
    input  logic             z,
    input  logic             c,
    input  logic             mem_rdy,
    input  logic             resume,
    output logic [RA_W-1:0]  w_adr,
    output logic [RA_W-1:0]  r_adr,
    output logic [RA_W-1:0]  s_adr,
    output logic             adr_sel,
    output logic             s_sel,
    output logic             pc_ld,
    output logic             pc_inc,
    output logic             pc_sel,
    output logic             ir_ld,
    output logic             mw_en,
    output logic             rw_en,
    output logic [ALU_W-1:0] alu_op,
    output logic [7:0]       status,
    output logic             halted,
    output logic             trap
);

    generate
        if (RA_W < 1 || 3 * RA_W > 12) begin : g_bad_ra_w
            $error("cu_seq_param: RA_W must satisfy 1 <= RA_W and 3*RA_W <= 12");
        end
        if (ALU_W < 4) begin : g_bad_alu_w
            $error("cu_seq_param: ALU_W must be at least 4");
        end
    endgenerate

    state_t          state;
    state_t          next_state;
    logic            mem_ok;
    logic            flag_ld;
    logic            ps_n;
    logic            ps_z;
    logic            ps_c;
    logic [3:0]      opcode;
    logic [RA_W-1:0] fld_w;
    logic [RA_W-1:0] fld_r;
    logic [RA_W-1:0] fld_s;
    logic [7:0]      exec_status;
    logic            unused_ir;

    assign opcode      = ir[15:12];
    assign fld_w       = ir[3*RA_W-1:2*RA_W];
    assign fld_r       = ir[2*RA_W-1:RA_W];
    assign fld_s       = ir[RA_W-1:0];
    assign exec_status = {ps_n, ps_z, ps_c, 1'b0, opcode};
    assign unused_ir   = ^ir;

`ifdef CU_SEQ_MEM_WAIT_EN
    assign mem_ok = mem_rdy;
`else
    logic unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;
    assign mem_ok         = 1'b1;
`endif

    cu_seq_flags u_flags (
        .clk   (clk),
        .reset (reset),
        .ld_en (flag_ld),
        .n     (n),
        .z     (z),
        .c     (c),
        .ps_n  (ps_n),
        .ps_z  (ps_z),
        .ps_c  (ps_c)
    );

    // State register; reset returns to RESET from anywhere, even mid-wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing, including memory stalls and the HALT/ILLEGAL sinks.
    always_comb begin
        next_state = state;
        case (state)
            ST_RESET:   next_state = ST_FETCH;
            ST_FETCH:   if (mem_ok) next_state = ST_DECODE;
            ST_DECODE:  begin
                if (ILLEGAL_MASK[opcode]) begin
                    next_state = ST_ILLEGAL;
                end else begin
                    next_state = state_t'({1'b0, opcode});
                end
            end
            ST_LD, ST_STO, ST_LDI: if (mem_ok) next_state = ST_FETCH;
            ST_HALT:    if (resume) next_state = ST_FETCH;
            ST_ILLEGAL: next_state = ST_ILLEGAL;
            default:    next_state = ST_FETCH;
        endcase
    end

    // Moore control word per state; memory-side strobes qualified by mem_ok.
    always_comb begin
        w_adr   = '0;
        r_adr   = '0;
        s_adr   = '0;
        adr_sel = 1'b0;
        s_sel   = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        pc_sel  = 1'b0;
        ir_ld   = 1'b0;
        mw_en   = 1'b0;
        rw_en   = 1'b0;
        alu_op  = '0;
        status  = exec_status;
        halted  = 1'b0;
        trap    = 1'b0;
        flag_ld = 1'b0;
        case (state)
            ST_RESET:   status = 8'hFF;
            ST_FETCH:   begin
                status = 8'h80;
                ir_ld  = mem_ok;
                pc_inc = mem_ok;
            end
            ST_DECODE:  status = 8'hC0;
            ST_ILLEGAL: begin
                status = 8'hF0;
                trap   = 1'b1;
            end
            ST_ADD:     begin
                w_adr = fld_w; r_adr = fld_r; s_adr = fld_s;
                rw_en = 1'b1; alu_op = ALU_W'(ALU_ADD); flag_ld = 1'b1;
            end
            ST_SUB:     begin
                w_adr = fld_w; r_adr = fld_r; s_adr = fld_s;
                rw_en = 1'b1; alu_op = ALU_W'(ALU_SUB); flag_ld = 1'b1;
            end
            ST_CMP:     begin
                r_adr = fld_r; s_adr = fld_s;
                alu_op = ALU_W'(ALU_SUB); flag_ld = 1'b1;
            end
            ST_MOV:     begin
                w_adr = fld_w; r_adr = fld_s; rw_en = 1'b1; alu_op = ALU_W'(ALU_PASS);
            end
            ST_SHL:     begin
                w_adr = fld_w; r_adr = fld_s; rw_en = 1'b1;
                alu_op = ALU_W'(ALU_SHL); flag_ld = 1'b1;
            end
            ST_SHR:     begin
                w_adr = fld_w; r_adr = fld_s; rw_en = 1'b1;
                alu_op = ALU_W'(ALU_SHR); flag_ld = 1'b1;
            end
            ST_INC:     begin
                w_adr = fld_w; r_adr = fld_s; rw_en = 1'b1;
                alu_op = ALU_W'(ALU_INC); flag_ld = 1'b1;
            end
            ST_DEC:     begin
                w_adr = fld_w; r_adr = fld_s; rw_en = 1'b1;
                alu_op = ALU_W'(ALU_DEC); flag_ld = 1'b1;
            end
            ST_LD:      begin
                w_adr = fld_w; r_adr = fld_s; adr_sel = 1'b1; s_sel = 1'b1;
                rw_en = mem_ok; alu_op = ALU_W'(ALU_MEM);
            end
            ST_STO:     begin
                r_adr = fld_w; s_adr = fld_s; adr_sel = 1'b1;
                mw_en = mem_ok; alu_op = ALU_W'(ALU_MEM);
            end
            ST_LDI:     begin
                w_adr = fld_w; s_sel = 1'b1; pc_inc = mem_ok; rw_en = mem_ok;
            end
            ST_HALT:    begin
                halted = 1'b1; alu_op = '1;
            end
            ST_JE:      pc_ld = ps_z;
            ST_JNE:     pc_ld = ~ps_z;
            ST_JC:      pc_ld = ps_c;
            ST_JMP:     begin
                r_adr = fld_s; pc_ld = 1'b1; pc_sel = 1'b1;
            end
            default:    status = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_cu_seq_param.sv
// Scoreboard bench for cu_seq_param: stimulus pushes hand-computed expected
// control words, a negedge monitor pops and compares both DUT instances
// (dut_a traps opcode 15, dut_b executes JMP).
module tb_cu_seq_param;

    localparam logic [7:0] C_ADR   = 8'h80;
    localparam logic [7:0] C_SSEL  = 8'h40;
    localparam logic [7:0] C_PCLD  = 8'h20;
    localparam logic [7:0] C_PCINC = 8'h10;
    localparam logic [7:0] C_PCSEL = 8'h08;
    localparam logic [7:0] C_IRLD  = 8'h04;
    localparam logic [7:0] C_MW    = 8'h02;
    localparam logic [7:0] C_RW    = 8'h01;

    typedef struct {
        logic [30:0] ea;
        logic [30:0] eb;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir;
    logic        n, z, c, mem_rdy, resume;

    logic [2:0] a_w_adr, a_r_adr, a_s_adr, b_w_adr, b_r_adr, b_s_adr;
    logic       a_adr_sel, a_s_sel, a_pc_ld, a_pc_inc, a_pc_sel, a_ir_ld, a_mw_en, a_rw_en;
    logic       b_adr_sel, b_s_sel, b_pc_ld, b_pc_inc, b_pc_sel, b_ir_ld, b_mw_en, b_rw_en;
    logic [3:0] a_alu_op, b_alu_op;
    logic [7:0] a_status, b_status;
    logic       a_halted, a_trap, b_halted, b_trap;

    logic [30:0] obs_a, obs_b;
    logic [30:0] fetch_e, dec_e, rst_e;
    exp_t        sb_q[$];
    exp_t        mon_item;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cu_seq_param #(.RA_W(3), .ALU_W(4), .ILLEGAL_MASK(16'h8000)) dut_a (
        .clk(clk), .reset(reset), .ir(ir), .n(n), .z(z), .c(c),
        .mem_rdy(mem_rdy), .resume(resume),
        .w_adr(a_w_adr), .r_adr(a_r_adr), .s_adr(a_s_adr),
        .adr_sel(a_adr_sel), .s_sel(a_s_sel), .pc_ld(a_pc_ld), .pc_inc(a_pc_inc),
        .pc_sel(a_pc_sel), .ir_ld(a_ir_ld), .mw_en(a_mw_en), .rw_en(a_rw_en),
        .alu_op(a_alu_op), .status(a_status), .halted(a_halted), .trap(a_trap)
    );

    cu_seq_param #(.RA_W(3), .ALU_W(4), .ILLEGAL_MASK(16'h0000)) dut_b (
        .clk(clk), .reset(reset), .ir(ir), .n(n), .z(z), .c(c),
        .mem_rdy(mem_rdy), .resume(resume),
        .w_adr(b_w_adr), .r_adr(b_r_adr), .s_adr(b_s_adr),
        .adr_sel(b_adr_sel), .s_sel(b_s_sel), .pc_ld(b_pc_ld), .pc_inc(b_pc_inc),
        .pc_sel(b_pc_sel), .ir_ld(b_ir_ld), .mw_en(b_mw_en), .rw_en(b_rw_en),
        .alu_op(b_alu_op), .status(b_status), .halted(b_halted), .trap(b_trap)
    );

    assign obs_a = {a_w_adr, a_r_adr, a_s_adr,
                    a_adr_sel, a_s_sel, a_pc_ld, a_pc_inc, a_pc_sel, a_ir_ld, a_mw_en, a_rw_en,
                    a_alu_op, a_status, a_halted, a_trap};
    assign obs_b = {b_w_adr, b_r_adr, b_s_adr,
                    b_adr_sel, b_s_sel, b_pc_ld, b_pc_inc, b_pc_sel, b_ir_ld, b_mw_en, b_rw_en,
                    b_alu_op, b_status, b_halted, b_trap};

    function automatic logic [30:0] mk(input int w, input int r, input int s,
                                       input logic [7:0] ctl, input logic [3:0] alu,
                                       input logic [7:0] st, input logic h, input logic t);
        logic [2:0] w3, r3, s3;
        w3 = w[2:0];
        r3 = r[2:0];
        s3 = s[2:0];
        return {w3, r3, s3, ctl, alu, st, h, t};
    endfunction

    task automatic checkOutput(input string nm, input logic [30:0] act, input logic [30:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (w,r,s,ctl,alu,status,halted,trap)",
                     nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] ir_v, input logic [2:0] nzc,
                                 input logic mr, input logic rs, input logic rst_v,
                                 input logic [30:0] ea, input logic [30:0] eb,
                                 input string nm);
        exp_t it;
        @(posedge clk);
        #1;
        ir = ir_v;
        {n, z, c} = nzc;
        mem_rdy = mr;
        resume = rs;
        reset = rst_v;
        it.ea = ea;
        it.eb = eb;
        it.nm = nm;
        sb_q.push_back(it);
    endtask

    task automatic doInstr(input logic [15:0] ir_v, input logic [2:0] nzc, input logic mr,
                           input logic [30:0] ea, input logic [30:0] eb, input string nm);
        applyStimulus(ir_v, 3'b000, 1'b1, 1'b0, 1'b0, fetch_e, fetch_e, {nm, "-fetch"});
        applyStimulus(ir_v, 3'b000, 1'b1, 1'b0, 1'b0, dec_e, dec_e, {nm, "-decode"});
        applyStimulus(ir_v, nzc, mr, 1'b0, 1'b0, ea, eb, {nm, "-exec"});
    endtask

    // Monitor: compare both DUTs against the oldest pending expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_item = sb_q.pop_front();
            checkOutput({mon_item.nm, "/a"}, obs_a, mon_item.ea);
            checkOutput({mon_item.nm, "/b"}, obs_b, mon_item.eb);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [30:0] e;
        logic [30:0] halt_e;
        logic [30:0] ill_e;
        reset = 1'b1; ir = 16'h0000; n = 1'b0; z = 1'b0; c = 1'b0;
        mem_rdy = 1'b1; resume = 1'b0;
        fetch_e = mk(0, 0, 0, C_IRLD | C_PCINC, 4'h0, 8'h80, 1'b0, 1'b0);
        dec_e   = mk(0, 0, 0, 8'h00, 4'h0, 8'hC0, 1'b0, 1'b0);
        rst_e   = mk(0, 0, 0, 8'h00, 4'h0, 8'hFF, 1'b0, 1'b0);

        applyStimulus(16'h0000, 3'b000, 1'b1, 1'b0, 1'b1, rst_e, rst_e, "reset-held");
        applyStimulus(16'h0053, 3'b000, 1'b1, 1'b0, 1'b0, rst_e, rst_e, "reset-state");

        e = mk(1, 2, 3, C_RW, 4'h2, 8'h00, 1'b0, 1'b0);
        doInstr(16'h0053, 3'b000, 1'b1, e, e, "add");
        e = mk(0, 4, 5, 8'h00, 4'h3, 8'h02, 1'b0, 1'b0);
        doInstr(16'h2025, 3'b010, 1'b1, e, e, "cmp-z1");
        e = mk(0, 0, 0, C_PCLD, 4'h0, 8'h4C, 1'b0, 1'b0);
        doInstr(16'hC000, 3'b101, 1'b1, e, e, "je-taken");
        e = mk(0, 4, 5, 8'h00, 4'h3, 8'h42, 1'b0, 1'b0);
        doInstr(16'h2025, 3'b000, 1'b1, e, e, "cmp-z0");
        e = mk(0, 0, 0, 8'h00, 4'h0, 8'h0C, 1'b0, 1'b0);
        doInstr(16'hC000, 3'b000, 1'b1, e, e, "je-not-taken");
        e = mk(1, 2, 3, C_RW, 4'h3, 8'h01, 1'b0, 1'b0);
        doInstr(16'h1053, 3'b101, 1'b1, e, e, "sub");
        e = mk(0, 0, 0, C_PCLD, 4'h0, 8'hAE, 1'b0, 1'b0);
        doInstr(16'hE000, 3'b000, 1'b1, e, e, "jc");
        e = mk(0, 0, 0, C_PCLD, 4'h0, 8'hAD, 1'b0, 1'b0);
        doInstr(16'hD000, 3'b000, 1'b1, e, e, "jne");
        e = mk(1, 3, 0, C_RW, 4'h0, 8'hA3, 1'b0, 1'b0);
        doInstr(16'h3053, 3'b000, 1'b1, e, e, "mov");
        e = mk(1, 3, 0, C_RW, 4'h7, 8'hA4, 1'b0, 1'b0);
        doInstr(16'h4053, 3'b010, 1'b1, e, e, "shl");
        e = mk(1, 3, 0, C_RW, 4'h6, 8'h45, 1'b0, 1'b0);
        doInstr(16'h5053, 3'b000, 1'b1, e, e, "shr");
        e = mk(1, 3, 0, C_RW, 4'h4, 8'h06, 1'b0, 1'b0);
        doInstr(16'h6053, 3'b100, 1'b1, e, e, "inc");
        e = mk(1, 3, 0, C_RW, 4'h5, 8'h87, 1'b0, 1'b0);
        doInstr(16'h7053, 3'b000, 1'b1, e, e, "dec");
        e = mk(1, 3, 0, C_ADR | C_SSEL | C_RW, 4'h1, 8'h08, 1'b0, 1'b0);
        doInstr(16'h8053, 3'b000, 1'b1, e, e, "ld");
        e = mk(0, 1, 3, C_ADR | C_MW, 4'h1, 8'h09, 1'b0, 1'b0);
        doInstr(16'h9053, 3'b000, 1'b1, e, e, "sto");
        e = mk(1, 0, 0, C_SSEL | C_PCINC | C_RW, 4'h0, 8'h0A, 1'b0, 1'b0);
        doInstr(16'hA053, 3'b000, 1'b1, e, e, "ldi");

`ifdef CU_SEQ_MEM_WAIT_EN
        e = mk(0, 0, 0, 8'h00, 4'h0, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h8053, 3'b000, 1'b0, 1'b0, 1'b0, e, e, "fetch-wait");
        end
        applyStimulus(16'h8053, 3'b000, 1'b1, 1'b0, 1'b0, fetch_e, fetch_e, "fetch-ready");
        applyStimulus(16'h8053, 3'b000, 1'b1, 1'b0, 1'b0, dec_e, dec_e, "ld-wait-decode");
        e = mk(1, 3, 0, C_ADR | C_SSEL, 4'h1, 8'h08, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(16'h8053, 3'b000, 1'b0, 1'b0, 1'b0, e, e, "ld-wait");
        end
        e = mk(1, 3, 0, C_ADR | C_SSEL | C_RW, 4'h1, 8'h08, 1'b0, 1'b0);
        applyStimulus(16'h8053, 3'b000, 1'b1, 1'b0, 1'b0, e, e, "ld-ready");
        applyStimulus(16'hA053, 3'b000, 1'b1, 1'b0, 1'b0, fetch_e, fetch_e, "ldi-wait-fetch");
        applyStimulus(16'hA053, 3'b000, 1'b1, 1'b0, 1'b0, dec_e, dec_e, "ldi-wait-decode");
        e = mk(1, 0, 0, C_SSEL, 4'h0, 8'h0A, 1'b0, 1'b0);
        applyStimulus(16'hA053, 3'b000, 1'b0, 1'b0, 1'b0, e, e, "ldi-wait");
        e = mk(1, 0, 0, C_SSEL | C_PCINC | C_RW, 4'h0, 8'h0A, 1'b0, 1'b0);
        applyStimulus(16'hA053, 3'b000, 1'b1, 1'b0, 1'b0, e, e, "ldi-ready");
`endif

        halt_e = mk(0, 0, 0, 8'h00, 4'hF, 8'h0B, 1'b1, 1'b0);
        doInstr(16'hB000, 3'b000, 1'b1, halt_e, halt_e, "halt");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(16'hB000, 3'b000, 1'b1, 1'b0, 1'b0, halt_e, halt_e, "halt-hold");
        end
        applyStimulus(16'hB000, 3'b000, 1'b1, 1'b1, 1'b0, halt_e, halt_e, "halt-resume");

        e = mk(1, 2, 3, C_RW, 4'h2, 8'h00, 1'b0, 1'b0);
        doInstr(16'h0053, 3'b111, 1'b1, e, e, "add-after-halt");
`ifdef CU_SEQ_MEM_WAIT_EN
        e = mk(0, 1, 3, C_ADR, 4'h1, 8'hE9, 1'b0, 1'b0);
`else
        e = mk(0, 1, 3, C_ADR | C_MW, 4'h1, 8'hE9, 1'b0, 1'b0);
`endif
        doInstr(16'h9053, 3'b000, 1'b0, e, e, "sto-before-reset");
        applyStimulus(16'h9053, 3'b000, 1'b0, 1'b0, 1'b1, rst_e, rst_e, "reset-in-sto");
        applyStimulus(16'hC000, 3'b000, 1'b1, 1'b0, 1'b0, rst_e, rst_e, "reset-release");
        e = mk(0, 0, 0, 8'h00, 4'h0, 8'h0C, 1'b0, 1'b0);
        doInstr(16'hC000, 3'b000, 1'b1, e, e, "je-flags-cleared");

        ill_e = mk(0, 0, 0, 8'h00, 4'h0, 8'hF0, 1'b0, 1'b1);
        e = mk(0, 3, 0, C_PCLD | C_PCSEL, 4'h0, 8'h0F, 1'b0, 1'b0);
        doInstr(16'hF053, 3'b000, 1'b1, ill_e, e, "jmp-or-illegal");
        applyStimulus(16'hF053, 3'b000, 1'b1, 1'b0, 1'b0, ill_e, fetch_e, "illegal-hold1");
        applyStimulus(16'hF053, 3'b000, 1'b1, 1'b0, 1'b0, ill_e, dec_e, "illegal-hold2");
        applyStimulus(16'hF053, 3'b000, 1'b1, 1'b0, 1'b0, ill_e, e, "illegal-hold3");
        applyStimulus(16'hF053, 3'b000, 1'b1, 1'b0, 1'b1, rst_e, rst_e, "illegal-reset");

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard-drain: %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
